// File: rtl/oped_axis_egress_arb.sv
// N-channel AXI4-Stream egress arbiter: packet-granular round-robin merge of
// DAT/TSTRB/TLAST plus LEN/SPT/DPT/ERR sidebands onto one registered stream.
module oped_axis_egress_arb #(
  parameter int NCH       = 4,
  parameter int DW        = 256,
  parameter int LENW      = 16,
  parameter int STAMP_SPT = 1,
  parameter int CW        = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [NCH*DW-1:0]     S_AXIS_DAT_TDATA,
  input  logic [NCH*DW/8-1:0]   S_AXIS_DAT_TSTRB,
  input  logic [NCH-1:0]        S_AXIS_DAT_TLAST,
  input  logic [NCH-1:0]        S_AXIS_DAT_TVALID,
  output logic [NCH-1:0]        S_AXIS_DAT_TREADY,
  input  logic [NCH*LENW-1:0]   S_AXIS_LEN_TDATA,
  input  logic [NCH*8-1:0]      S_AXIS_SPT_TDATA,
  input  logic [NCH*8-1:0]      S_AXIS_DPT_TDATA,
  input  logic [NCH-1:0]        S_AXIS_ERR_TDATA,
  output logic [DW-1:0]         M_AXIS_DAT_TDATA,
  output logic [DW/8-1:0]       M_AXIS_DAT_TSTRB,
  output logic                  M_AXIS_DAT_TLAST,
  output logic                  M_AXIS_DAT_TVALID,
  input  logic                  M_AXIS_DAT_TREADY,
  output logic [LENW-1:0]       M_AXIS_LEN_TDATA,
  output logic [7:0]            M_AXIS_SPT_TDATA,
  output logic [7:0]            M_AXIS_DPT_TDATA,
  output logic                  M_AXIS_ERR_TDATA,
  output logic [NCH-1:0]        GRANT,
  output logic [CW-1:0]         PKT_COUNT,
  output logic [CW-1:0]         STALL_COUNT
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = DW / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [DW-1:0]   tdata_q, tdata_d;
  logic [SW-1:0]   tstrb_q, tstrb_d;
  logic            tlast_q, tlast_d;
  logic            tvalid_q, tvalid_d;
  logic [LENW-1:0] len_q, len_d;
  logic [7:0]      spt_q, spt_d;
  logic [7:0]      dpt_q, dpt_d;
  logic            err_q, err_d;
  logic [CW-1:0]   pkt_q, pkt_d;
  logic [CW-1:0]   stall_q, stall_d;

  logic            out_ready;
  logic            acc;
  logic            found;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   sel;
  int              gi;

  assign out_ready = !tvalid_q || M_AXIS_DAT_TREADY;
  assign acc       = (state_q == BUSY) && out_ready && S_AXIS_DAT_TVALID[gidx_q];
  assign gi        = int'(gidx_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_d     = rr_q;
    tdata_d  = tdata_q;
    tstrb_d  = tstrb_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    len_d    = len_q;
    spt_d    = spt_q;
    dpt_d    = dpt_q;
    err_d    = err_q;
    pkt_d    = pkt_q;
    stall_d  = stall_q;
    found    = 1'b0;
    cand     = '0;
    sel      = '0;

    case (state_q)
      IDLE: begin
        // Search starts just past the last granted channel and wraps.
        for (int k = 1; k <= NCH; k++) begin
          cand = IW'((int'(rr_q) + k) % NCH);
          if (!found && S_AXIS_DAT_TVALID[cand]) begin
            found = 1'b1;
            sel   = cand;
          end
        end
        if (found) begin
          state_d = BUSY;
          gidx_d  = sel;
          grant_d = NCH'(1) << sel;
        end
      end
      BUSY: begin
        if (acc && S_AXIS_DAT_TLAST[gidx_q]) begin
          state_d = IDLE;
          rr_d    = gidx_q;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (acc) begin
      tvalid_d = 1'b1;
      tdata_d  = S_AXIS_DAT_TDATA[gi*DW +: DW];
      tstrb_d  = S_AXIS_DAT_TSTRB[gi*SW +: SW];
      tlast_d  = S_AXIS_DAT_TLAST[gidx_q];
      len_d    = S_AXIS_LEN_TDATA[gi*LENW +: LENW];
      dpt_d    = S_AXIS_DPT_TDATA[gi*8 +: 8];
      err_d    = S_AXIS_ERR_TDATA[gidx_q];
      spt_d    = (STAMP_SPT != 0) ? 8'(gidx_q) : S_AXIS_SPT_TDATA[gi*8 +: 8];
    end else if (M_AXIS_DAT_TREADY) begin
      tvalid_d = 1'b0;
    end

    if (tvalid_q && M_AXIS_DAT_TREADY && tlast_q) pkt_d = pkt_q + CW'(1);
    if (tvalid_q && !M_AXIS_DAT_TREADY) stall_d = stall_q + CW'(1);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_q     <= IW'(NCH - 1);
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      len_q    <= '0;
      spt_q    <= '0;
      dpt_q    <= '0;
      err_q    <= 1'b0;
      pkt_q    <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_q     <= rr_d;
      tdata_q  <= tdata_d;
      tstrb_q  <= tstrb_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      len_q    <= len_d;
      spt_q    <= spt_d;
      dpt_q    <= dpt_d;
      err_q    <= err_d;
      pkt_q    <= pkt_d;
      stall_q  <= stall_d;
    end
  end

  assign S_AXIS_DAT_TREADY = ((state_q == BUSY) && out_ready) ? grant_q : '0;
  assign M_AXIS_DAT_TDATA  = tdata_q;
  assign M_AXIS_DAT_TSTRB  = tstrb_q;
  assign M_AXIS_DAT_TLAST  = tlast_q;
  assign M_AXIS_DAT_TVALID = tvalid_q;
  assign M_AXIS_LEN_TDATA  = len_q;
  assign M_AXIS_SPT_TDATA  = spt_q;
  assign M_AXIS_DPT_TDATA  = dpt_q;
  assign M_AXIS_ERR_TDATA  = err_q;
  assign GRANT             = grant_q;
  assign PKT_COUNT         = pkt_q;
  assign STALL_COUNT       = stall_q;

endmodule

// File: tb/tb_oped_axis_egress_arb.sv
// Directed bench for oped_axis_egress_arb: one stamping instance and one
// pass-through SPT instance share the same input stimulus.
module tb_oped_axis_egress_arb;

  localparam int NCH  = 4;
  localparam int DW   = 16;
  localparam int LENW = 16;
  localparam int CW   = 8;

  logic                ACLK = 1'b0;
  logic                ARESETN;
  logic [NCH*DW-1:0]   s_tdata;
  logic [NCH*DW/8-1:0] s_tstrb;
  logic [NCH-1:0]      s_tlast, s_tvalid, s_err;
  logic [NCH*LENW-1:0] s_len;
  logic [NCH*8-1:0]    s_spt, s_dpt;
  logic                m_tready;

  logic [NCH-1:0]  s_tready0, s_tready1;
  logic [DW-1:0]   m_tdata0, m_tdata1;
  logic [DW/8-1:0] m_tstrb0, m_tstrb1;
  logic            m_tlast0, m_tlast1, m_tvalid0, m_tvalid1;
  logic [LENW-1:0] m_len0, m_len1;
  logic [7:0]      m_spt0, m_spt1, m_dpt0, m_dpt1;
  logic            m_err0, m_err1;
  logic [NCH-1:0]  grant0, grant1;
  logic [CW-1:0]   pkt0, pkt1, stall0, stall1;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 ACLK = ~ACLK;

  oped_axis_egress_arb #(.NCH(NCH), .DW(DW), .LENW(LENW), .STAMP_SPT(1), .CW(CW)) u_stamp (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_DAT_TDATA(s_tdata), .S_AXIS_DAT_TSTRB(s_tstrb), .S_AXIS_DAT_TLAST(s_tlast),
    .S_AXIS_DAT_TVALID(s_tvalid), .S_AXIS_DAT_TREADY(s_tready0),
    .S_AXIS_LEN_TDATA(s_len), .S_AXIS_SPT_TDATA(s_spt), .S_AXIS_DPT_TDATA(s_dpt),
    .S_AXIS_ERR_TDATA(s_err),
    .M_AXIS_DAT_TDATA(m_tdata0), .M_AXIS_DAT_TSTRB(m_tstrb0), .M_AXIS_DAT_TLAST(m_tlast0),
    .M_AXIS_DAT_TVALID(m_tvalid0), .M_AXIS_DAT_TREADY(m_tready),
    .M_AXIS_LEN_TDATA(m_len0), .M_AXIS_SPT_TDATA(m_spt0), .M_AXIS_DPT_TDATA(m_dpt0),
    .M_AXIS_ERR_TDATA(m_err0), .GRANT(grant0), .PKT_COUNT(pkt0), .STALL_COUNT(stall0)
  );

  oped_axis_egress_arb #(.NCH(NCH), .DW(DW), .LENW(LENW), .STAMP_SPT(0), .CW(CW)) u_pass (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_DAT_TDATA(s_tdata), .S_AXIS_DAT_TSTRB(s_tstrb), .S_AXIS_DAT_TLAST(s_tlast),
    .S_AXIS_DAT_TVALID(s_tvalid), .S_AXIS_DAT_TREADY(s_tready1),
    .S_AXIS_LEN_TDATA(s_len), .S_AXIS_SPT_TDATA(s_spt), .S_AXIS_DPT_TDATA(s_dpt),
    .S_AXIS_ERR_TDATA(s_err),
    .M_AXIS_DAT_TDATA(m_tdata1), .M_AXIS_DAT_TSTRB(m_tstrb1), .M_AXIS_DAT_TLAST(m_tlast1),
    .M_AXIS_DAT_TVALID(m_tvalid1), .M_AXIS_DAT_TREADY(m_tready),
    .M_AXIS_LEN_TDATA(m_len1), .M_AXIS_SPT_TDATA(m_spt1), .M_AXIS_DPT_TDATA(m_dpt1),
    .M_AXIS_ERR_TDATA(m_err1), .GRANT(grant1), .PKT_COUNT(pkt1), .STALL_COUNT(stall1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic vld, input logic [DW-1:0] d,
                        input logic last, input logic [7:0] spt, input logic [7:0] dpt,
                        input logic err, input logic [LENW-1:0] len);
    s_tvalid[ch]             = vld;
    s_tdata[ch*DW +: DW]     = d;
    s_tstrb[ch*DW/8 +: DW/8] = '1;
    s_tlast[ch]              = last;
    s_spt[ch*8 +: 8]         = spt;
    s_dpt[ch*8 +: 8]         = dpt;
    s_err[ch]                = err;
    s_len[ch*LENW +: LENW]   = len;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    tick();
    tick();
    ARESETN = 1'b1;
  endtask

  initial begin
    ARESETN  = 1'b0;
    s_tdata  = '0; s_tstrb = '0; s_tlast = '0; s_tvalid = '0; s_err = '0;
    s_len    = '0; s_spt   = '0; s_dpt   = '0;
    m_tready = 1'b1;
    do_reset();

    // Reset state
    check("rst_grant", grant0, 0);
    check("rst_tvalid", m_tvalid0, 0);
    check("rst_tdata", m_tdata0, 0);
    check("rst_pkt", pkt0, 0);
    check("rst_stall", stall0, 0);
    check("rst_tready", s_tready0, 0);

    // Channel 2: 3-beat packet, stamped SPT must be 2 regardless of input SPT
    set_ch(2, 1, 16'h00A0, 0, 8'h99, 8'h05, 0, 16'd3);
    tick();
    check("t1_grant", grant0, 4'b0100);
    check("t1_idle_no_out", m_tvalid0, 0);
    tick();
    check("t1_b0", m_tdata0, 16'h00A0);
    check("t1_b0_vld", m_tvalid0, 1);
    check("t1_b0_last", m_tlast0, 0);
    set_ch(2, 1, 16'h00A1, 0, 8'h99, 8'h05, 0, 16'd3);
    tick();
    check("t1_b1", m_tdata0, 16'h00A1);
    set_ch(2, 1, 16'h00A2, 1, 8'h99, 8'h05, 0, 16'd3);
    tick();
    check("t1_b2", m_tdata0, 16'h00A2);
    check("t1_b2_last", m_tlast0, 1);
    check("t1_spt", m_spt0, 8'h02);
    check("t1_dpt", m_dpt0, 8'h05);
    check("t1_len", m_len0, 16'd3);
    check("t1_strb", m_tstrb0, 2'b11);
    check("t1_grant_idle", grant0, 0);
    set_ch(2, 0, 16'h0000, 0, 8'h00, 8'h00, 0, 16'd0);
    tick();
    check("t1_pkt", pkt0, 1);
    check("t1_drain", m_tvalid0, 0);

    // All channels offer single-beat packets: grant order 0,1,2,3,0,1
    do_reset();
    for (int c = 0; c < NCH; c++) set_ch(c, 1, 16'h0010 + 16'(c), 1, 8'h00, 8'h00, 0, 16'd1);
    for (int p = 0; p < 6; p++) begin
      tick();
      check($sformatf("t2_grant%0d", p), grant0, 4'b0001 << (p % 4));
      tick();
      check($sformatf("t2_data%0d", p), m_tdata0, 16'h0010 + 16'(p % 4));
      check($sformatf("t2_gap%0d", p), grant0, 0);
    end
    s_tvalid = '0;
    tick();
    check("t2_pkt", pkt0, 6);

    // Channel 1 4-beat packet; channel 0 requests mid-packet and must wait
    set_ch(1, 1, 16'h0020, 0, 8'h00, 8'h00, 0, 16'd4);
    tick();
    check("t3_grant1", grant0, 4'b0010);
    tick();
    check("t3_b0", m_tdata0, 16'h0020);
    set_ch(0, 1, 16'h0030, 1, 8'h00, 8'h00, 0, 16'd1);
    set_ch(1, 1, 16'h0021, 0, 8'h00, 8'h00, 0, 16'd4);
    tick();
    check("t3_b1", m_tdata0, 16'h0021);
    check("t3_hold_grant", grant0, 4'b0010);
    check("t3_ch0_blocked", s_tready0[0], 0);
    set_ch(1, 1, 16'h0022, 0, 8'h00, 8'h00, 0, 16'd4);
    tick();
    check("t3_b2", m_tdata0, 16'h0022);
    set_ch(1, 1, 16'h0023, 1, 8'h00, 8'h00, 0, 16'd4);
    tick();
    check("t3_b3", m_tdata0, 16'h0023);
    check("t3_b3_last", m_tlast0, 1);
    check("t3_idle", grant0, 0);
    set_ch(1, 0, 16'h0000, 0, 8'h00, 8'h00, 0, 16'd0);
    tick();
    check("t3_grant0", grant0, 4'b0001);
    tick();
    check("t3_ch0_data", m_tdata0, 16'h0030);
    set_ch(0, 0, 16'h0000, 0, 8'h00, 8'h00, 0, 16'd0);
    tick();

    // Downstream stall for 5 cycles in the middle of a channel 3 packet
    set_ch(3, 1, 16'h0040, 0, 8'h00, 8'h00, 0, 16'd2);
    tick();
    check("t4_grant", grant0, 4'b1000);
    tick();
    check("t4_b0", m_tdata0, 16'h0040);
    m_tready = 1'b0;
    set_ch(3, 1, 16'h0041, 1, 8'h00, 8'h00, 0, 16'd2);
    #1;
    check("t4_tready_off", s_tready0, 0);
    for (int s = 0; s < 5; s++) begin
      tick();
      check($sformatf("t4_hold%0d", s), m_tdata0, 16'h0040);
      check($sformatf("t4_vld%0d", s), m_tvalid0, 1);
      check($sformatf("t4_srdy%0d", s), s_tready0, 0);
    end
    check("t4_stall", stall0, 5);
    m_tready = 1'b1;
    #1;
    check("t4_tready_on", s_tready0, 4'b1000);
    tick();
    check("t4_b1", m_tdata0, 16'h0041);
    check("t4_b1_last", m_tlast0, 1);
    set_ch(3, 0, 16'h0000, 0, 8'h00, 8'h00, 0, 16'd0);
    tick();
    check("t4_drain", m_tvalid0, 0);
    check("t4_stall_end", stall0, 5);

    // Reset during beat 2 of a 4-beat packet
    set_ch(0, 1, 16'h0050, 0, 8'h00, 8'h00, 0, 16'd4);
    tick();
    check("t5_grant", grant0, 4'b0001);
    tick();
    check("t5_b0", m_tdata0, 16'h0050);
    set_ch(0, 1, 16'h0051, 0, 8'h00, 8'h00, 0, 16'd4);
    tick();
    check("t5_b1", m_tdata0, 16'h0051);
    ARESETN = 1'b0;
    set_ch(0, 1, 16'h0060, 1, 8'h00, 8'h00, 0, 16'd1);
    set_ch(1, 1, 16'h0070, 1, 8'h00, 8'h00, 0, 16'd1);
    tick();
    ARESETN = 1'b1;
    check("t5_rst_vld", m_tvalid0, 0);
    check("t5_rst_grant", grant0, 0);
    check("t5_rst_pkt", pkt0, 0);
    check("t5_rst_stall", stall0, 0);
    tick();
    check("t5_regrant0", grant0, 4'b0001);
    tick();
    check("t5_new_data", m_tdata0, 16'h0060);
    set_ch(0, 0, 16'h0000, 0, 8'h00, 8'h00, 0, 16'd0);
    tick();
    check("t5_next_grant1", grant0, 4'b0010);
    tick();
    check("t5_ch1_data", m_tdata0, 16'h0070);
    set_ch(1, 0, 16'h0000, 0, 8'h00, 8'h00, 0, 16'd0);
    tick();

    // SPT pass-through versus stamping, plus ERR/LEN sidebands from channel 3
    set_ch(3, 1, 16'h0080, 1, 8'h7E, 8'h11, 1, 16'h0123);
    tick();
    check("t6_grant", grant1, 4'b1000);
    tick();
    check("t6_pass_spt", m_spt1, 8'h7E);
    check("t6_pass_err", m_err1, 1);
    check("t6_stamp_spt", m_spt0, 8'h03);
    check("t6_len", m_len1, 16'h0123);
    check("t6_dpt", m_dpt1, 8'h11);
    set_ch(3, 0, 16'h0000, 0, 8'h00, 8'h00, 0, 16'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
